ctrl_sequencer: RTL and testbench

Parametrised one-hot step sequencer that generalises the fixed six-output CONTROL block. It drives NUM_STEPS datapath step enables with a programmable per-step dwell, supports one-shot or looping runs, has a start/done handshake, and routes datapath overflow to a dedicated recovery step with a sticky flag. It sits between the top-level control inputs and the counter/accumulator datapath.

---
 rtl/ctrl_sequencer.sv | 126 ++++++++++++
 tb/tb_ctrl_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// One-hot step sequencer with a programmable per-step dwell, one-shot or looping runs,
// and a dedicated overflow-recovery step that raises a sticky flag.
module ctrl_sequencer #(
    parameter int unsigned NUM_STEPS = 6,
    parameter int unsigned DWELL_W   = 4,
    parameter bit          LOOP      = 1'b1,
    parameter int unsigned OVF_STEP  = NUM_STEPS - 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         CLR,
    input  logic                         EN,
    input  logic                         START,
    input  logic                         OVERFLOW,
    input  logic [DWELL_W-1:0]           DWELL,
    output logic [NUM_STEPS-1:0]         S,
    output logic [$clog2(NUM_STEPS)-1:0] STEP_IDX,
    output logic                         BUSY,
    output logic                         DONE,
    output logic                         OVF_FLAG
);

    localparam int unsigned IDX_W = $clog2(NUM_STEPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);
    localparam logic [IDX_W-1:0] OVF_IDX  = IDX_W'(OVF_STEP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_OVF
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     step_q, step_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 flag_q, flag_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            flag_q  <= flag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        flag_d  = flag_q;

        if (CLR) begin
            state_d = ST_IDLE;
            step_d  = '0;
            cnt_d   = '0;
            flag_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        state_d = ST_RUN;
                        step_d  = '0;
                        cnt_d   = DWELL;
                    end
                end
                ST_RUN: begin
                    // Overflow preempts the step advance and ignores EN.
                    if (OVERFLOW) begin
                        state_d = ST_OVF;
                        step_d  = OVF_IDX;
                        cnt_d   = DWELL;
                        flag_d  = 1'b1;
                    end else if (EN) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - DWELL_W'(1);
                        end else if (step_q == LAST_IDX) begin
                            done_d = 1'b1;
                            step_d = '0;
                            if (LOOP) begin
                                cnt_d = DWELL;
                            end else begin
                                state_d = ST_IDLE;
                                cnt_d   = '0;
                            end
                        end else begin
                            step_d = step_q + IDX_W'(1);
                            cnt_d  = DWELL;
                        end
                    end
                end
                ST_OVF: begin
                    if (EN) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - DWELL_W'(1);
                        end else begin
                            state_d = ST_IDLE;
                            step_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign BUSY     = (state_q != ST_IDLE);
    assign S        = BUSY ? ({{(NUM_STEPS-1){1'b0}}, 1'b1} << step_q) : '0;
    assign STEP_IDX = step_q;
    assign DONE     = done_q;
    assign OVF_FLAG = flag_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: a one-shot and a looping instance share stimulus;
// expected snapshots are queued per cycle and checked by an independent negedge monitor.
module tb_ctrl_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       CLR = 1'b0;
    logic       EN = 1'b0;
    logic       START = 1'b0;
    logic       OVERFLOW = 1'b0;
    logic [3:0] DWELL = '0;

    logic [5:0] s0, s1;
    logic [2:0] idx0, idx1;
    logic       busy0, busy1, done0, done1, flag0, flag1;

    ctrl_sequencer #(.NUM_STEPS(6), .DWELL_W(4), .LOOP(1'b0), .OVF_STEP(5)) u_oneshot (
        .CLK(CLK), .RST(RST), .CLR(CLR), .EN(EN), .START(START), .OVERFLOW(OVERFLOW),
        .DWELL(DWELL), .S(s0), .STEP_IDX(idx0), .BUSY(busy0), .DONE(done0), .OVF_FLAG(flag0)
    );

    ctrl_sequencer #(.NUM_STEPS(6), .DWELL_W(4), .LOOP(1'b1), .OVF_STEP(5)) u_loop (
        .CLK(CLK), .RST(RST), .CLR(CLR), .EN(EN), .START(START), .OVERFLOW(OVERFLOW),
        .DWELL(DWELL), .S(s1), .STEP_IDX(idx1), .BUSY(busy1), .DONE(done1), .OVF_FLAG(flag1)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [5:0] s;
        logic [2:0] idx;
        logic       busy;
        logic       done;
        logic       flag;
    } snap_t;

    snap_t exp_q[$];
    string name_q[$];
    bit    sel_q[$];
    int    n_checks = 0;
    int    n_fail = 0;

    // step < 0 means IDLE.
    function automatic snap_t mk(int step, bit dn, bit fl);
        snap_t e;
        e.s    = '0;
        e.idx  = '0;
        e.busy = 1'b0;
        if (step >= 0) begin
            e.s[step] = 1'b1;
            e.idx     = 3'(step);
            e.busy    = 1'b1;
        end
        e.done = dn;
        e.flag = fl;
        return e;
    endfunction

    function automatic snap_t act(bit sel);
        if (sel) return {s1, idx1, busy1, done1, flag1};
        return {s0, idx0, busy0, done0, flag0};
    endfunction

    function automatic void compare(snap_t a, snap_t e, string nm);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got S=%b idx=%0d busy=%b done=%b flag=%b, want S=%b idx=%0d busy=%b done=%b flag=%b",
                     nm, a.s, a.idx, a.busy, a.done, a.flag, e.s, e.idx, e.busy, e.done, e.flag);
        end
    endfunction

    always @(negedge CLK) begin
        snap_t e;
        string nm;
        bit    sel;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            sel = sel_q.pop_front();
            compare(act(sel), e, nm);
        end
    end

    task automatic cyc(input bit st, input bit en, input bit ov, input bit cl, input logic [3:0] dw,
                       input bit sel, input int step, input bit dn, input bit fl, input string nm);
        START    = st;
        EN       = en;
        OVERFLOW = ov;
        CLR      = cl;
        DWELL    = dw;
        @(posedge CLK);
        exp_q.push_back(mk(step, dn, fl));
        name_q.push_back(nm);
        sel_q.push_back(sel);
        #1;
        START    = 1'b0;
        EN       = 1'b0;
        OVERFLOW = 1'b0;
        CLR      = 1'b0;
    endtask

    initial begin
        #2;
        compare(act(1'b0), mk(-1, 0, 0), "reset_oneshot");
        compare(act(1'b1), mk(-1, 0, 0), "reset_loop");
        @(posedge CLK);
        @(posedge CLK);
        #1 RST = 1'b1;

        // One-shot, DWELL=1, START held high through the run (must not restart).
        cyc(1, 1, 0, 0, 4'd1, 0, 0, 0, 0, "os_start");
        for (int k = 1; k <= 11; k++) cyc(1, 1, 0, 0, 4'd1, 0, k / 2, 0, 0, $sformatf("os_step_e%0d", k));
        cyc(0, 1, 0, 0, 4'd1, 0, -1, 1, 0, "os_done");
        cyc(0, 1, 0, 0, 4'd1, 0, -1, 0, 0, "os_idle_after");
        cyc(0, 0, 0, 1, 4'd1, 1, -1, 0, 0, "clr_loop");

        // Looping, DWELL=0, EN high only on even edges: two cycles per step.
        cyc(1, 0, 0, 0, 4'd0, 1, 0, 0, 0, "lp_start");
        for (int k = 1; k <= 25; k++)
            cyc(0, (k % 2) == 0, 0, 0, 4'd0, 1, (k / 2) % 6, (k % 12) == 0, 0, $sformatf("lp_e%0d", k));
        cyc(0, 0, 0, 1, 4'd0, 1, -1, 0, 0, "clr_loop2");

        // Overflow during step 2 with DWELL=2; a repeated overflow in OVF is ignored.
        cyc(1, 1, 0, 0, 4'd2, 0, 0, 0, 0, "ov_start");
        for (int k = 1; k <= 6; k++) cyc(0, 1, 0, 0, 4'd2, 0, k / 3, 0, 0, $sformatf("ov_step_e%0d", k));
        cyc(0, 1, 1, 0, 4'd2, 0, 5, 0, 1, "ov_enter");
        cyc(0, 1, 1, 0, 4'd2, 0, 5, 0, 1, "ov_second_ignored");
        cyc(0, 1, 0, 0, 4'd2, 0, 5, 0, 1, "ov_dwell");
        cyc(0, 1, 0, 0, 4'd2, 0, -1, 0, 1, "ov_exit_no_done");
        cyc(0, 1, 1, 0, 4'd2, 0, -1, 0, 1, "ov_idle_ignored");
        cyc(0, 1, 0, 0, 4'd2, 0, -1, 0, 1, "ov_flag_sticky");

        // CLR and OVERFLOW on the same edge during step 3; flag is still set from above.
        cyc(1, 1, 0, 0, 4'd0, 0, 0, 0, 1, "cp_start");
        for (int k = 1; k <= 3; k++) cyc(0, 1, 0, 0, 4'd0, 0, k, 0, 1, $sformatf("cp_step%0d", k));
        cyc(0, 1, 1, 1, 4'd0, 0, -1, 0, 0, "cp_clr_wins");

        // START together with CLR in IDLE stays IDLE.
        cyc(1, 1, 0, 1, 4'd0, 0, -1, 0, 0, "start_clr");
        cyc(0, 1, 0, 0, 4'd0, 1, -1, 0, 0, "start_clr_after");

        // Asynchronous reset in the middle of a run.
        cyc(1, 1, 0, 0, 4'd1, 0, 0, 0, 0, "ar_start");
        for (int k = 1; k <= 4; k++) cyc(0, 1, 0, 0, 4'd1, 0, k / 2, 0, 0, $sformatf("ar_e%0d", k));
        @(negedge CLK);
        #1 RST = 1'b0;
        #1;
        compare(act(1'b0), mk(-1, 0, 0), "ar_async_oneshot");
        compare(act(1'b1), mk(-1, 0, 0), "ar_async_loop");
        @(posedge CLK);
        #1 RST = 1'b1;
        cyc(0, 1, 0, 0, 4'd1, 0, -1, 0, 0, "ar_idle1");
        cyc(0, 1, 0, 0, 4'd1, 1, -1, 0, 0, "ar_idle2");
        cyc(1, 1, 0, 0, 4'd1, 0, 0, 0, 0, "ar_restart");
        cyc(0, 1, 0, 0, 4'd1, 0, 0, 0, 0, "ar_dwell");

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge CLK);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
